// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped branch target buffer with a 2-bit saturating counter in each
// entry. Lookup is purely combinational (zero-cycle latency) for the IF stage.
// The ID stage resolves branches, raises mispredict_o for the flush and
// redirect, and trains the table on the next rising edge.
//
// Ports
//   clk_i              single clock, rising edge
//   rst_i              asynchronous, active-low reset
//   pc_i               fetch PC to look up
//   pred_hit_o         valid entry with a matching tag at index(pc_i)
//   pred_taken_o       hit and counter MSB set
//   pred_target_o      stored target on hit, pc_i+4 otherwise
//   clear_i            synchronous invalidate of every entry
//   upd_valid_i        a branch is resolved this cycle
//   upd_pc_i           PC of the resolved branch
//   upd_taken_i        actual outcome
//   upd_target_i       actual taken target
//   upd_pred_taken_i   direction predicted at fetch
//   upd_pred_target_i  target predicted at fetch
//   mispredict_o       combinational mispredict flag
//
// Optional feature (macro BPRED_STATS_EN)
//   lookup_cnt_o   saturating count of cycles with upd_valid_i = 1
//   mispred_cnt_o  saturating count of cycles with mispredict_o = 1
//   Both are cleared by reset only; clear_i leaves them alone.
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              clear_i,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [ADDR_W-1:0] upd_pred_target_i,
`ifdef BPRED_STATS_EN
  output logic [31:0]       lookup_cnt_o,
  output logic [31:0]       mispred_cnt_o,
`endif
  output logic              mispredict_o
);

  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-3){1'b0}}, 3'd4};

  // Saturating increment of a 2-bit direction counter.
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'd1;
  endfunction

  // Saturating decrement of a 2-bit direction counter.
  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  // Byte-offset bits of the PCs never reach the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_i[1:0], upd_pc_i[1:0]};

  assign lk_idx = pc_i[IDX_W+1:2];
  assign lk_tag = pc_i[ADDR_W-1:IDX_W+2];
  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Fetch-side lookup: reads stored state only, so a same-cycle update is not
  // visible until after the edge.
  always_comb begin
    pred_hit_o    = 1'b0;
    pred_taken_o  = 1'b0;
    pred_target_o = pc_i + PC_STEP;
    if (valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag)) begin
      pred_hit_o    = 1'b1;
      pred_taken_o  = ctr_q[lk_idx][1];
      pred_target_o = target_q[lk_idx];
    end else begin
      pred_hit_o    = 1'b0;
    end
  end

  // Wrong direction, or right direction (taken) with the wrong target.
  always_comb begin
    mispredict_o = upd_valid_i &&
                   ((upd_pred_taken_i != upd_taken_i) ||
                    (upd_taken_i && (upd_pred_target_i != upd_target_i)));
  end

  // Table training; clear has priority over any update, and a miss that was
  // not taken leaves the table untouched.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (clear_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_valid_i) begin
      if (up_hit) begin
        if (upd_taken_i) begin
          ctr_q[up_idx]    <= ctr_inc(ctr_q[up_idx]);
          target_q[up_idx] <= upd_target_i;
        end else begin
          ctr_q[up_idx]    <= ctr_dec(ctr_q[up_idx]);
        end
      end else if (upd_taken_i) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target_i;
        ctr_q[up_idx]    <= 2'b10;
      end
    end
  end

`ifdef BPRED_STATS_EN
  // Saturating event counters; deliberately untouched by clear_i.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lookup_cnt_o  <= 32'd0;
      mispred_cnt_o <= 32'd0;
    end else begin
      if (upd_valid_i && (lookup_cnt_o != 32'hFFFF_FFFF)) begin
        lookup_cnt_o <= lookup_cnt_o + 32'd1;
      end
      if (mispredict_o && (mispred_cnt_o != 32'hFFFF_FFFF)) begin
        mispred_cnt_o <= mispred_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Self-checking bench for branch_predictor (ENTRIES=16, ADDR_W=32). A reference
// model keyed by the word address (pc >> 2) tracks which branch owns each slot,
// its target and its counter as a plain integer 0..3.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        pred_hit_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        clear_i;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_pred_taken_i;
  logic [31:0] upd_pred_target_i;
  logic        mispredict_o;
`ifdef BPRED_STATS_EN
  logic [31:0] lookup_cnt_o;
  logic [31:0] mispred_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  bit          m_valid [16];
  logic [31:0] m_key   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int          exp_lookups = 0;
  int          exp_mispred = 0;

  branch_predictor dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .pc_i              (pc_i),
    .pred_hit_o        (pred_hit_o),
    .pred_taken_o      (pred_taken_o),
    .pred_target_o     (pred_target_o),
    .clear_i           (clear_i),
    .upd_valid_i       (upd_valid_i),
    .upd_pc_i          (upd_pc_i),
    .upd_taken_i       (upd_taken_i),
    .upd_target_i      (upd_target_i),
    .upd_pred_taken_i  (upd_pred_taken_i),
    .upd_pred_target_i (upd_pred_target_i),
`ifdef BPRED_STATS_EN
    .lookup_cnt_o      (lookup_cnt_o),
    .mispred_cnt_o     (mispred_cnt_o),
`endif
    .mispredict_o      (mispredict_o)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_key[idx_of(pc)] == (pc >> 2));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_key[i]   = 32'd0;
      m_tgt[i]   = 32'd0;
      m_ctr[i]   = 1;
    end
  endfunction

  function automatic void model_update(input bit clr, input bit uv, input logic [31:0] upc,
                                       input bit t, input logic [31:0] tgt);
    int i;
    i = idx_of(upc);
    if (clr) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
    end else if (uv) begin
      if (model_hit(upc)) begin
        if (t) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = tgt;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (t) begin
        m_valid[i] = 1'b1;
        m_key[i]   = upc >> 2;
        m_tgt[i]   = tgt;
        m_ctr[i]   = 2;
      end
    end
  endfunction

  // One clock cycle: drive, sample before the edge against the model, clock,
  // advance the model. Called 1 time unit after a rising edge.
  task automatic run_cycle(input string nm, input logic [31:0] lpc,
                           input bit uv, input logic [31:0] upc, input bit t,
                           input logic [31:0] tgt, input bit pt, input logic [31:0] ptgt,
                           input bit clr,
                           output logic o_hit, output logic o_taken,
                           output logic [31:0] o_tgt, output logic o_mis);
    bit          e_hit, e_taken, e_mis;
    logic [31:0] e_tgt;
    pc_i = lpc; upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = t;
    upd_target_i = tgt; upd_pred_taken_i = pt; upd_pred_target_i = ptgt; clear_i = clr;
    #1;
    e_hit   = model_hit(lpc);
    e_taken = e_hit && (m_ctr[idx_of(lpc)] >= 2);
    e_tgt   = e_hit ? m_tgt[idx_of(lpc)] : lpc + 32'd4;
    e_mis   = uv && ((pt != t) || (t && (ptgt != tgt)));
    o_hit = pred_hit_o; o_taken = pred_taken_o; o_tgt = pred_target_o; o_mis = mispredict_o;
    total += 4;
    if (pred_hit_o !== e_hit) begin
      bad++; $display("FAIL %s hit pc=%h got %b want %b", nm, lpc, pred_hit_o, e_hit);
    end
    if (pred_taken_o !== e_taken) begin
      bad++; $display("FAIL %s taken pc=%h got %b want %b", nm, lpc, pred_taken_o, e_taken);
    end
    if (pred_target_o !== e_tgt) begin
      bad++; $display("FAIL %s target pc=%h got %h want %h", nm, lpc, pred_target_o, e_tgt);
    end
    if (mispredict_o !== e_mis) begin
      bad++; $display("FAIL %s mispredict got %b want %b", nm, mispredict_o, e_mis);
    end
    if (uv) exp_lookups++;
    if (e_mis) exp_mispred++;
    @(posedge clk);
    model_update(clr, uv, upc, t, tgt);
    #1;
  endtask

  task automatic idle_lookup(input string nm, input logic [31:0] lpc,
                             output logic h, output logic tk, output logic [31:0] tg);
    logic m;
    run_cycle(nm, lpc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, h, tk, tg, m);
  endtask

  task automatic test_reset();
    rst_i = 1'b0; clear_i = 1'b0; upd_valid_i = 1'b0; upd_pc_i = 32'd0; upd_taken_i = 1'b0;
    upd_target_i = 32'd0; upd_pred_taken_i = 1'b0; upd_pred_target_i = 32'd0;
    pc_i = 32'h0000_0040;
    model_reset();
    #2;
    total += 3;
    if (pred_hit_o !== 1'b0) begin bad++; $display("FAIL reset_hit got %b want 0", pred_hit_o); end
    if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL reset_taken got %b want 0", pred_taken_o); end
    if (pred_target_o !== 32'h0000_0044) begin
      bad++; $display("FAIL reset_target got %h want 00000044", pred_target_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;
    exp_lookups = 0; exp_mispred = 0;
    #1;
    total += 2;
    if (pred_hit_o !== 1'b0) begin bad++; $display("FAIL post_reset_hit got %b want 0", pred_hit_o); end
    if (pred_target_o !== 32'h0000_0044) begin
      bad++; $display("FAIL post_reset_target got %h want 00000044", pred_target_o);
    end
`ifdef BPRED_STATS_EN
    total += 1;
    if (lookup_cnt_o !== 32'd0 || mispred_cnt_o !== 32'd0) begin
      bad++; $display("FAIL reset_stats got %0d/%0d want 0/0", lookup_cnt_o, mispred_cnt_o);
    end
`endif
  endtask

  task automatic test_alloc();
    logic h, tk, m; logic [31:0] tg;
    run_cycle("alloc", 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, h, tk, tg, m);
    total += 1;
    if (m !== 1'b1) begin bad++; $display("FAIL alloc_mispredict got %b want 1", m); end
    idle_lookup("alloc_look", 32'h40, h, tk, tg);
    total += 3;
    if (h !== 1'b1) begin bad++; $display("FAIL alloc_hit got %b want 1", h); end
    if (tk !== 1'b1) begin bad++; $display("FAIL alloc_taken got %b want 1", tk); end
    if (tg !== 32'h100) begin bad++; $display("FAIL alloc_target got %h want 00000100", tg); end
  endtask

  // Starts at counter 10; each cycle samples the state before its update.
  task automatic test_counter_walk();
    bit   outcome [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit   want_tk [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic h, tk, m; logic [31:0] tg;
    for (int i = 0; i < 9; i++) begin
      if (i < 8)
        run_cycle("walk", 32'h40, 1'b1, 32'h40, outcome[i], 32'h100, 1'b1, 32'h100,
                  1'b0, h, tk, tg, m);
      else
        idle_lookup("walk_end", 32'h40, h, tk, tg);
      total += 2;
      if (h !== 1'b1) begin bad++; $display("FAIL walk_hit step=%0d got %b want 1", i, h); end
      if (tk !== want_tk[i]) begin
        bad++; $display("FAIL walk_taken step=%0d got %b want %b", i, tk, want_tk[i]);
      end
    end
  endtask

  task automatic test_alias();
    logic h, tk, m; logic [31:0] tg;
    run_cycle("alias_upd", 32'h40, 1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, h, tk, tg, m);
    idle_lookup("alias_old", 32'h40, h, tk, tg);
    total += 1;
    if (h !== 1'b0) begin bad++; $display("FAIL alias_old_hit got %b want 0", h); end
    idle_lookup("alias_new", 32'h80, h, tk, tg);
    total += 3;
    if (h !== 1'b1) begin bad++; $display("FAIL alias_new_hit got %b want 1", h); end
    if (tk !== 1'b1) begin bad++; $display("FAIL alias_new_taken got %b want 1", tk); end
    if (tg !== 32'h200) begin bad++; $display("FAIL alias_new_target got %h want 00000200", tg); end
    // Counter 10 -> one not-taken gives 01, so the direction flips.
    run_cycle("alias_nt", 32'h80, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, h, tk, tg, m);
    idle_lookup("alias_ctr", 32'h80, h, tk, tg);
    total += 1;
    if (tk !== 1'b0) begin bad++; $display("FAIL alias_ctr_taken got %b want 0", tk); end
  endtask

  task automatic test_same_cycle();
    logic h, tk, m; logic [31:0] tg;
    run_cycle("sc_alloc", 32'h0, 1'b1, 32'h40, 1'b1, 32'h140, 1'b1, 32'h140, 1'b0, h, tk, tg, m);
    run_cycle("sc_upd", 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h140, 1'b0, h, tk, tg, m);
    total += 1;
    if (tk !== 1'b1) begin bad++; $display("FAIL same_cycle_taken got %b want 1", tk); end
    idle_lookup("sc_after", 32'h40, h, tk, tg);
    total += 1;
    if (tk !== 1'b0) begin bad++; $display("FAIL same_cycle_next_taken got %b want 0", tk); end
  endtask

  task automatic test_clear_with_update();
    logic h, tk, m; logic [31:0] tg;
    run_cycle("clr_upd", 32'h40, 1'b1, 32'h40, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1, h, tk, tg, m);
    for (int i = 0; i < 16; i++) begin
      idle_lookup("clr_look", 32'h40 + 32'(i * 4), h, tk, tg);
      total += 1;
      if (h !== 1'b0) begin bad++; $display("FAIL clear_empty slot=%0d got %b want 0", i, h); end
    end
  endtask

  task automatic test_reset_mid_update();
    logic h, tk, m; logic [31:0] tg;
    run_cycle("mr_alloc", 32'h48, 1'b1, 32'h48, 1'b1, 32'h480, 1'b1, 32'h480, 1'b0, h, tk, tg, m);
    pc_i = 32'h48; upd_valid_i = 1'b1; upd_pc_i = 32'h4C; upd_taken_i = 1'b1;
    upd_target_i = 32'h4C0; clear_i = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    total += 1;
    if (pred_hit_o !== 1'b0) begin bad++; $display("FAIL async_reset_hit got %b want 0", pred_hit_o); end
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    model_reset();
    exp_lookups = 0; exp_mispred = 0;
    idle_lookup("mr_lost", 32'h4C, h, tk, tg);
    total += 1;
    if (h !== 1'b0) begin bad++; $display("FAIL reset_lost_update got %b want 0", h); end
  endtask

  task automatic test_random();
    logic h, tk, m; logic [31:0] tg;
    logic [31:0] lpc, upc, tgt, ptgt;
    bit uv, t, pt, clr;
    for (int n = 0; n < 400; n++) begin
      lpc  = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      upc  = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) upc = upc | 32'h8000_0000;
      tgt  = $urandom & 32'hFFFF_FFFC;
      ptgt = ($urandom_range(0, 2) == 0) ? ($urandom & 32'hFFFF_FFFC) : tgt;
      uv   = ($urandom_range(0, 9) < 6);
      t    = $urandom_range(0, 1) == 1;
      pt   = $urandom_range(0, 1) == 1;
      clr  = ($urandom_range(0, 49) == 0);
      run_cycle("random", lpc, uv, upc, t, tgt, pt, ptgt, clr, h, tk, tg, m);
    end
  endtask

`ifdef BPRED_STATS_EN
  task automatic test_stats();
    logic h, tk, m; logic [31:0] tg;
    bit   mis_sel [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    rst_i = 1'b0; #1; @(posedge clk); #1; rst_i = 1'b1; model_reset();
    for (int i = 0; i < 5; i++)
      run_cycle("stats_upd", 32'h0, 1'b1, 32'h100 + 32'(i * 4), 1'b1, 32'h900,
                1'b1, mis_sel[i] ? 32'h904 : 32'h900, 1'b0, h, tk, tg, m);
    total += 2;
    if (lookup_cnt_o !== 32'd5) begin bad++; $display("FAIL stats_lookup got %0d want 5", lookup_cnt_o); end
    if (mispred_cnt_o !== 32'd2) begin bad++; $display("FAIL stats_mispred got %0d want 2", mispred_cnt_o); end
    run_cycle("stats_clr", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, h, tk, tg, m);
    total += 2;
    if (lookup_cnt_o !== 32'd5) begin bad++; $display("FAIL stats_clear_lookup got %0d want 5", lookup_cnt_o); end
    if (mispred_cnt_o !== 32'd2) begin bad++; $display("FAIL stats_clear_mispred got %0d want 2", mispred_cnt_o); end
    rst_i = 1'b0; #1;
    total += 2;
    if (lookup_cnt_o !== 32'd0) begin bad++; $display("FAIL stats_reset_lookup got %0d want 0", lookup_cnt_o); end
    if (mispred_cnt_o !== 32'd0) begin bad++; $display("FAIL stats_reset_mispred got %0d want 0", mispred_cnt_o); end
    @(posedge clk); #1; rst_i = 1'b1; model_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_alloc();
    test_counter_walk();
    test_alias();
    test_same_cycle();
    test_clear_with_update();
    test_reset_mid_update();
    test_random();
`ifdef BPRED_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
